// File: rtl/m_fetch.sv
// m_fetch: program counter, sequential instruction-memory reads and a small {inst, pc} queue.
// Latency: request in cycle N, response in N+1, visible at the queue head in N+2 (no bypass).
// Backpressure: valid/ready at the head; fetch stalls while queued + in-flight fills the queue.

// m_fetch_fifo: circular buffer with flush and a zeroed head while empty.
// Latency: a push becomes visible at the head on the following cycle.
// Backpressure: the caller must never push while full; the head pops on head_vld & pop_rdy.
module m_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     w_clk,
  input  logic                     w_rst,
  input  logic                     flush,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_rdy,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count != '0);
  assign do_pop   = head_vld & pop_rdy;
  // A flush wins over a push arriving in the same cycle.
  assign do_push  = push_vld & ~flush;
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)      count <= count + (AW+1)'(1);
      else if (~do_push & do_pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the queue is empty.
  always_ff @(posedge w_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module m_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr,
  input  logic [31:0] w_imem_data,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        w_inst_valid,
  input  logic        w_inst_ready,
  output logic [31:0] w_inst,
  output logic [31:0] w_inst_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_pend;
  logic [CW-1:0] q_count;
  logic [CW:0]   occ;
  fq_entry_t     push_entry;
  fq_entry_t     head_entry;
  logic          head_vld;

  // Occupancy counts the in-flight word so the queue can never overflow;
  // a pop in the same cycle is deliberately not credited.
  assign occ         = {1'b0, q_count} + {{CW{1'b0}}, r_pend};
  assign w_imem_req  = ~w_rst & ~w_redirect & (occ < (CW+1)'(DEPTH));
  assign w_imem_addr = r_pc;

  assign push_entry = '{inst: w_imem_data, pc: r_pend_pc};

  m_fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .flush    (w_redirect),
    .push_vld (r_pend),
    .push_dat (push_entry),
    .pop_rdy  (w_inst_ready),
    .head_vld (head_vld),
    .head_dat (head_entry),
    .count    (q_count)
  );

  assign w_inst_valid = head_vld;
  assign w_inst       = head_entry.inst;
  assign w_inst_pc    = head_entry.pc;

  // PC advance and in-flight tracking; a redirect cancels the pending response and retargets.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_pc      <= RESET_PC & ~32'h3;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else if (w_redirect) begin
      r_pc      <= w_redirect_pc & ~32'h3;
      r_pend    <= 1'b0;
    end else if (w_imem_req) begin
      r_pc      <= r_pc + 32'd4;
      r_pend    <= 1'b1;
      r_pend_pc <= r_pc;
    end else begin
      r_pend    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_m_fetch.sv
// tb_m_fetch: scoreboard bench for m_fetch with a 1-cycle instruction memory model.
// Latency: checks the 2-cycle request-to-head delay after reset and redirect.
// Backpressure: exercises ready=0 fill, drain, redirect-while-full and random ready.
module tb_m_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_inst_valid;
  logic        w_inst_ready = 1'b0;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] dlv_q[$];
  logic [31:0] gen_pc;

  always #5 w_clk = ~w_clk;

  m_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .w_clk         (w_clk),
    .w_rst         (w_rst),
    .w_imem_req    (w_imem_req),
    .w_imem_addr   (w_imem_addr),
    .w_imem_data   (w_imem_data),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_inst_valid  (w_inst_valid),
    .w_inst_ready  (w_inst_ready),
    .w_inst        (w_inst),
    .w_inst_pc     (w_inst_pc)
  );

  // imem[i] = 0x100 + i, word-indexed
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h100 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: after reset or redirect to T the delivered stream is T, T+4, T+8, ...
  function automatic void sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void sb_restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
    sb_fill();
  endfunction

  // Synchronous memory: data for a request appears in the next cycle, garbage otherwise.
  always @(posedge w_clk) begin
    w_imem_data <= w_imem_req ? mem_word(w_imem_addr) : 32'hDEAD_BEEF;
  end

  // Monitor: compares every accepted head against the reference stream.
  always @(negedge w_clk) begin
    logic [31:0] e;
    if (!w_rst) begin
      if (w_inst_valid && w_inst_ready) begin
        hs_cnt++;
        dlv_q.push_back(w_inst_pc);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got pc %h expected none", w_inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", w_inst_pc, e);
          chk("sb_inst", w_inst, mem_word(e));
          sb_fill();
        end
      end
      if (!w_inst_valid) begin
        chk("empty_inst", w_inst, 32'h0);
        chk("empty_pc", w_inst_pc, 32'h0);
      end
      if (w_imem_req) chk("addr_align", {30'b0, w_imem_addr[1:0]}, 32'h0);
      if (w_redirect) sb_restart(w_redirect_pc);
    end
  end

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge w_clk);
    #1;
  endtask

  // Assert reset for two cycles; returns in cycle 0 after release.
  task automatic do_reset();
    w_rst      = 1'b1;
    w_redirect = 1'b0;
    sb_restart(RESET_PC);
    step();
    step();
    w_rst = 1'b0;
    dlv_q.delete();
  endtask

  // Called just after a settle(); returns the number of cycles waited or -1 on timeout.
  task automatic wait_valid(input int bound, output int waited);
    waited = -1;
    for (int i = 0; i < bound; i++) begin
      if (w_inst_valid) begin
        waited = i;
        break;
      end
      step();
      settle();
    end
    if (waited < 0) begin
      n_chk++;
      $display("FAIL wait_valid: got timeout expected valid within %0d cycles", bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int h0;
    int h1;
    logic [31:0] tgt;

    // ---- reset state and first stream ----
    w_inst_ready = 1'b1;
    sb_restart(RESET_PC);
    step();
    step();
    settle();
    chk("rst_valid", 32'(w_inst_valid), 32'd0);
    chk("rst_req", 32'(w_imem_req), 32'd0);
    chk("rst_inst", w_inst, 32'h0);
    chk("rst_pc", w_inst_pc, 32'h0);
    step();
    w_rst = 1'b0;
    dlv_q.delete();
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (c == 0) begin
        chk("first_req", 32'(w_imem_req), 32'd1);
        chk("first_addr", w_imem_addr, RESET_PC);
      end
      if (w_inst_valid) begin
        lat = c;
        break;
      end
      step();
    end
    chk("first_latency", 32'(lat), 32'd2);
    h0 = hs_cnt;
    repeat (8) begin
      step();
      settle();
    end
    chk("throughput", 32'(hs_cnt - h0), 32'd8);
    chk("stream0_pc", dlv_q[0], 32'h0);
    chk("stream1_pc", dlv_q[1], 32'h4);
    chk("stream2_pc", dlv_q[2], 32'h8);

    // ---- backpressure: fill, hold, drain ----
    step();
    w_inst_ready = 1'b0;
    do_reset();
    repeat (10) begin
      settle();
      step();
    end
    settle();
    chk("full_req", 32'(w_imem_req), 32'd0);
    chk("full_addr", w_imem_addr, 32'd16);
    chk("full_head_pc", w_inst_pc, 32'h0);
    step();
    w_inst_ready = 1'b1;
    h0 = hs_cnt;
    settle();
    chk("drain_no_credit", 32'(w_imem_req), 32'd0);
    step();
    settle();
    chk("resume_req", 32'(w_imem_req), 32'd1);
    chk("resume_addr", w_imem_addr, 32'd16);
    step();
    settle();
    step();
    settle();
    h1 = hs_cnt;
    chk("drain_count", 32'(h1 - h0), 32'd4);
    step();
    settle();
    chk("drain_next_pc", w_inst_pc, 32'd16);

    // ---- redirect with a response in flight ----
    step();
    do_reset();
    repeat (6) step();
    settle();
    chk("pre_redir_req", 32'(w_imem_req), 32'd1);
    step();
    w_redirect    = 1'b1;
    w_redirect_pc = 32'h40;
    settle();
    chk("redir_cycle_req", 32'(w_imem_req), 32'd0);
    step();
    w_redirect = 1'b0;
    settle();
    chk("post_redir_req", 32'(w_imem_req), 32'd1);
    chk("post_redir_addr", w_imem_addr, 32'h40);
    chk("post_redir_valid", 32'(w_inst_valid), 32'd0);
    wait_valid(10, lat);
    chk("redir_latency", 32'(lat), 32'd2);
    chk("redir_first_pc", w_inst_pc, 32'h40);
    chk("redir_first_inst", w_inst, 32'h110);

    // ---- redirect while full, ready=1, misaligned target ----
    step();
    w_inst_ready = 1'b0;
    do_reset();
    repeat (8) begin
      settle();
      step();
    end
    w_inst_ready  = 1'b1;
    w_redirect    = 1'b1;
    w_redirect_pc = 32'h43;
    h0 = hs_cnt;
    settle();
    chk("full_redir_valid", 32'(w_inst_valid), 32'd1);
    chk("full_redir_head", w_inst_pc, 32'h0);
    step();
    w_redirect = 1'b0;
    settle();
    chk("full_redir_pops", 32'(hs_cnt - h0), 32'd1);
    chk("full_redir_flush", 32'(w_inst_valid), 32'd0);
    chk("misalign_addr", w_imem_addr, 32'h40);
    wait_valid(10, lat);
    chk("misalign_first_pc", w_inst_pc, 32'h40);

    // ---- wrap-around ----
    step();
    w_redirect    = 1'b1;
    w_redirect_pc = 32'hFFFF_FFF8;
    step();
    w_redirect = 1'b0;
    dlv_q.delete();
    repeat (8) step();
    settle();
    chk("wrap_cnt_ok", 32'(dlv_q.size() >= 3), 32'd1);
    if (dlv_q.size() >= 3) begin
      chk("wrap_pc0", dlv_q[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", dlv_q[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", dlv_q[2], 32'h0000_0000);
    end

    // ---- asynchronous reset mid-stream ----
    step();
    settle();
    chk("pre_arst_valid", 32'(w_inst_valid), 32'd1);
    #2;
    w_rst = 1'b1;
    sb_restart(RESET_PC);
    #1;
    chk("arst_valid", 32'(w_inst_valid), 32'd0);
    chk("arst_req", 32'(w_imem_req), 32'd0);
    chk("arst_pc", w_inst_pc, 32'h0);
    step();
    step();
    w_rst = 1'b0;
    dlv_q.delete();
    settle();
    wait_valid(10, lat);
    chk("arst_latency", 32'(lat), 32'd2);
    chk("arst_first_pc", w_inst_pc, RESET_PC);

    // ---- randomized ready and redirects ----
    for (int i = 0; i < 600; i++) begin
      step();
      w_inst_ready = ($urandom_range(0, 9) < 7);
      w_redirect   = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      w_redirect_pc = tgt;
    end
    step();
    w_redirect   = 1'b0;
    w_inst_ready = 1'b1;
    h0 = hs_cnt;
    repeat (12) step();
    settle();
    chk("final_flow", 32'(hs_cnt - h0 >= 8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/m_fetch.md
Name: m_fetch

Overview:
- Instruction-fetch front end that sits directly upstream of the execute stage.
- Owns the program counter and issues sequential word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Hands instructions downstream over a valid/ready handshake. A redirect input (taken branch or jump) flushes the buffer and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, instruction-queue entries; must be a power of two and at least 2.
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
- w_clk  input  1  clock; all state updates on the rising edge.
- w_rst  input  1  reset; asynchronous, active-high.
- w_imem_req  output  1  read request to the instruction memory this cycle.
- w_imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
- w_imem_data  input  32  read data; valid in the cycle after a request is issued.
- w_redirect  input  1  redirect fetch; single-cycle pulse.
- w_redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.
- w_inst_valid  output  1  queue head is valid.
- w_inst_ready  input  1  downstream accepts the head this cycle.
- w_inst  output  32  instruction at the queue head.
- w_inst_pc  output  32  PC of the instruction at the queue head.

Behaviour:
- Reset (asynchronous, while w_rst=1):
  - r_pc=RESET_PC, count=0, r_pend=0, read and write pointers=0.
  - Outputs: w_imem_req=0, w_inst_valid=0, w_inst=0, w_inst_pc=0. w_inst and w_inst_pc read as 0 whenever the queue is empty.
  - The first request is issued in the first cycle after w_rst deasserts.
- State:
  - r_pc: address of the next request.
  - r_pend: a response is due in the current cycle.
  - r_pend_pc: PC of the in-flight request.
  - Circular queue of {inst, pc}, count in the range 0..DEPTH.
- Request rule:
  - w_imem_req = !w_rst & !w_redirect & (count + r_pend < DEPTH).
  - The rule is deliberately conservative: a pop in the same cycle is not credited. This makes overflow impossible.
  - w_imem_addr = r_pc.
  - On a request edge: r_pc <= r_pc+4, r_pend <= 1, r_pend_pc <= r_pc. Otherwise r_pend <= 0.
- Response:
  - When r_pend=1 and there is no redirect, {w_imem_data, r_pend_pc} is pushed at the tail at the end of the cycle.
  - Latency from request to w_inst_valid is 2 cycles: response in cycle N+1, visible at the head in cycle N+2.
- Dequeue:
  - A pop occurs when w_inst_valid & w_inst_ready.
  - Head outputs are driven combinationally from queue storage.
  - A push and a pop in the same cycle leave count unchanged.
  - When count=0 and a push occurs, the entry becomes visible the next cycle. There is no bypass.
- Throughput: with DEPTH>=3 and w_inst_ready held at 1, one instruction per cycle in steady state.
- Redirect (priority over everything except reset):
  - Queue flushes: count=0, pointers reset.
  - The response arriving in the same cycle is discarded. r_pend <= 0.
  - r_pc <= {w_redirect_pc[31:2], 2'b00}.
  - No request is issued in the redirect cycle. The first request to the target is issued the next cycle.
  - w_inst_valid is 0 in the cycle after a redirect.
  - A pop handshake in the redirect cycle is still honoured downstream. The entry is simply gone afterwards.
- Back-to-back redirects: each redirect cancels the previous one. The last target wins.
- Wrap-around: r_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, modulo 2^32, with no flag.
- Full queue: while count + r_pend >= DEPTH, w_imem_req=0 and r_pc holds.
- Reset mid-operation: all queue contents and the pending response are discarded immediately. The response arriving after reset release is not enqueued.

Test Plan:
- Reset release, imem[i]=32'h100+i, ready=1 -> requests at 0,4,8,...; head valid at cycle 2 after release; stream (pc,inst)=(0,0x100),(4,0x101),(8,0x102) with one accepted per cycle.
- Backpressure: ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued (pc 0..12), w_imem_req=0 with r_pc=16 held; set ready=1 -> in-order drain, fetch resumes at 16, no loss or duplication.
- Redirect with response in flight: pulse w_redirect with target 0x40 while r_pend=1 -> pending word dropped, no request in the redirect cycle, next request addr=0x40, valid=0 in the following cycle, first delivered pc=0x40.
- Redirect while full and ready=1 -> the pop in that cycle completes; all remaining entries are flushed; the next delivered pc is the target; a misaligned target 0x43 fetches from 0x40.
- Wrap: redirect to 0xFFFFFFF8 -> delivered pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Asynchronous reset asserted mid-stream between clock edges -> w_inst_valid=0 and w_imem_req=0 immediately; after release the first delivered pc is RESET_PC.
